// File: rtl/clk_div_pkg.sv
// Shared constants for the UART bit-clock divider.
// Ratios at or below BYPASS_MAX_RATIO pass the reference clock straight through.
package clk_div_pkg;

   localparam int RATIO_WIDTH_DEF  = 8;
   localparam int BYPASS_MAX_RATIO = 1;

endpackage

// File: rtl/clk_div.sv
// Integer clock divider (odd and even ratios); ratio 0/1 or clk_en=0 bypasses to clk.
// Outputs are registered except the bypass mux; a new ratio is adopted only at the end of a high phase.
module clk_div
   import clk_div_pkg::*;
#(
   parameter int RATIO_WIDTH = RATIO_WIDTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clk_en,
   input  logic [RATIO_WIDTH-1:0] div_ratio,
   output logic                   o_div_clk,
   output logic                   o_div_tick
);

   localparam logic [RATIO_WIDTH-1:0] BYP_MAX = RATIO_WIDTH'(BYPASS_MAX_RATIO);
   localparam logic [RATIO_WIDTH-1:0] ONE_R   = RATIO_WIDTH'(1);
   localparam logic [RATIO_WIDTH-2:0] ONE_C   = (RATIO_WIDTH-1)'(1);

   logic [RATIO_WIDTH-1:0] ratio_q, ratio_d;
   logic [RATIO_WIDTH-2:0] cnt_q, cnt_d;
   logic                   div_clk_q, div_clk_d;
   logic                   tick_q, tick_d;

   logic                   bypass;
   logic [RATIO_WIDTH-1:0] half, low_last, high_last, cnt_ext;

   assign bypass    = !clk_en || (ratio_q <= BYP_MAX);
   assign half      = ratio_q >> 1;
   // Low phase is ceil(N/2) cycles; (N>>1)+N[0] cannot overflow for N < 2^RATIO_WIDTH.
   assign low_last  = half + RATIO_WIDTH'(ratio_q[0]) - ONE_R;
   assign high_last = half - ONE_R;
   assign cnt_ext   = {1'b0, cnt_q};

   always_comb begin
      ratio_d   = ratio_q;
      cnt_d     = cnt_q;
      div_clk_d = div_clk_q;
      tick_d    = 1'b0;
      if (bypass) begin
         ratio_d   = clk_en ? div_ratio : '0;
         cnt_d     = '0;
         div_clk_d = 1'b0;
      end else if (!div_clk_q) begin
         if (cnt_ext == low_last) begin
            div_clk_d = 1'b1;
            cnt_d     = '0;
            tick_d    = 1'b1;
         end else begin
            cnt_d = cnt_q + ONE_C;
         end
      end else begin
         if (cnt_ext == high_last) begin
            div_clk_d = 1'b0;
            cnt_d     = '0;
            ratio_d   = div_ratio;
         end else begin
            cnt_d = cnt_q + ONE_C;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ratio_q   <= '0;
         cnt_q     <= '0;
         div_clk_q <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         ratio_q   <= ratio_d;
         cnt_q     <= cnt_d;
         div_clk_q <= div_clk_d;
         tick_q    <= tick_d;
      end
   end

   // Bypass must stay a combinational mux so the output is a true copy of clk.
   assign o_div_clk  = bypass ? clk : div_clk_q;
   assign o_div_tick = tick_q;

endmodule

// File: tb/tb_clk_div.sv
// Directed bench for clk_div: hand-computed waveforms per ratio, sampled 1ns after each clock edge.
module tb_clk_div;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clk_en = 1'b0;
   logic [7:0] div_ratio = 8'd0;
   logic       o_div_clk;
   logic       o_div_tick;

   int n_chk = 0;
   int n_err = 0;
   int n;

   clk_div #(.RATIO_WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .clk_en     (clk_en),
      .div_ratio  (div_ratio),
      .o_div_clk  (o_div_clk),
      .o_div_tick (o_div_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      clk_en    = 1'b0;
      div_ratio = 8'd0;
      repeat (2) @(negedge clk);
   endtask

   task automatic start(input logic [7:0] ratio);
      @(negedge clk);
      rst       = 1'b0;
      clk_en    = 1'b1;
      div_ratio = ratio;
   endtask

   // ck/tk hold the expected o_div_clk / o_div_tick after each successive rising edge.
   task automatic run_pat(input string tag, input string ck, input string tk);
      for (int i = 0; i < ck.len(); i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("%s_clk%0d", tag, i), o_div_clk, (ck[i] == "1"));
         chk($sformatf("%s_tick%0d", tag, i), o_div_tick, (tk[i] == "1"));
      end
   endtask

   task automatic bypass_chk(input string tag, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("%s_hi%0d", tag, i), o_div_clk, 1);
         chk($sformatf("%s_tick%0d", tag, i), o_div_tick, 0);
         @(negedge clk);
         #1;
         chk($sformatf("%s_lo%0d", tag, i), o_div_clk, 0);
      end
   endtask

   // Entered with the current sample already at lvl; leaves on the first sample that differs.
   task automatic run_len(input logic lvl, output int len);
      len = 0;
      do begin
         len++;
         @(posedge clk);
         #1;
      end while (o_div_clk == lvl && len < 600);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state: bypass, tick low
      repeat (3) @(negedge clk);
      bypass_chk("reset", 2);

      // N=4: low 2 / high 2
      start(8'd4);
      run_pat("n4", "001100110011", "001000100010");

      // N=5: low 3 / high 2
      do_reset();
      start(8'd5);
      run_pat("n5", "0001100011", "0001000010");

      // N=0 then N=1 stay in bypass
      do_reset();
      start(8'd0);
      bypass_chk("n0", 4);
      div_ratio = 8'd1;
      bypass_chk("n1", 4);

      // N=8, switch to 2 during the second high cycle
      do_reset();
      start(8'd8);
      run_pat("n8a", "000011", "000010");
      div_ratio = 8'd2;
      run_pat("n8b", "11010101", "00010101");

      // N=255: low 128 / high 127, then reset mid-high
      do_reset();
      start(8'd255);
      @(posedge clk);
      #1;
      chk("n255_first", o_div_clk, 0);
      run_len(1'b0, n);
      chk("n255_low", n, 128);
      chk("n255_tick", o_div_tick, 1);
      run_len(1'b1, n);
      chk("n255_high", n, 127);
      run_len(1'b0, n);
      chk("n255_low2", n, 128);
      repeat (10) @(posedge clk);
      #1;
      chk("n255_midhigh", o_div_clk, 1);
      rst = 1'b1;
      #1;
      chk("rst_divq", dut.div_clk_q, 0);
      chk("rst_tick", o_div_tick, 0);
      chk("rst_clk_hi", o_div_clk, 1);
      @(negedge clk);
      #1;
      chk("rst_clk_lo", o_div_clk, 0);
      start(8'd255);
      @(posedge clk);
      #1;
      chk("n255_restart", o_div_clk, 0);
      run_len(1'b0, n);
      chk("n255_low3", n, 128);

      // N=6, drop clk_en during the high phase, then re-enable
      do_reset();
      start(8'd6);
      run_pat("n6a", "000111", "000100");
      clk_en = 1'b0;
      #1;
      chk("en_off_hi", o_div_clk, 1);
      chk("en_off_tick", o_div_tick, 0);
      @(negedge clk);
      #1;
      chk("en_off_lo", o_div_clk, 0);
      bypass_chk("en_off", 1);
      @(negedge clk);
      clk_en = 1'b1;
      run_pat("n6b", "000111000111", "000100000100");

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
